vc_credit_tracker: RTL and testbench

//  Per-VC credit bookkeeping for one output port; sits directly upstream of priority_encoder.

---
 rtl/vc_credit_tracker_if.sv | 39 +++
 rtl/vc_credit_tracker.sv | 87 ++++++++
 tb/tb_vc_credit_tracker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vc_credit_tracker_if.sv
// Grant/credit/allows bundle between the priority encoder side and the credit tracker.
// Optional feature macro: VC_CREDIT_ERR_EN adds the sticky credit_err flag.
interface vc_credit_tracker_if #(
  parameter int unsigned no_vc                   = 15,
  parameter int unsigned floorplusone_log2_no_vc = 4
);
  logic                               grant_valid;
  logic [floorplusone_log2_no_vc-1:0] grant_vc;
  logic                               credit_valid;
  logic [floorplusone_log2_no_vc-1:0] credit_vc;
  logic [no_vc-1:0]                   allows;
`ifdef VC_CREDIT_ERR_EN
  logic                               credit_err;
`endif

  // Upstream side: sends flits and forwards returned credits, consumes allows.
  modport master (
    output grant_valid,
    output grant_vc,
    output credit_valid,
    output credit_vc,
`ifdef VC_CREDIT_ERR_EN
    input  credit_err,
`endif
    input  allows
  );

  // Tracker side.
  modport slave (
    input  grant_valid,
    input  grant_vc,
    input  credit_valid,
    input  credit_vc,
`ifdef VC_CREDIT_ERR_EN
    output credit_err,
`endif
    output allows
  );
endinterface

// File: rtl/vc_credit_tracker.sv
// Per-VC downstream credit counters for one output port. allows[k] is high while VC k has at
// least one free downstream slot; it is decoded only from registered counters.
// Optional feature macro: VC_CREDIT_ERR_EN enables the sticky credit_err protocol flag
// (underflow, overflow or out-of-range index). Without it, violations are silently absorbed.
module vc_credit_tracker #(
  parameter int unsigned no_vc                   = 15,
  parameter int unsigned floorplusone_log2_no_vc = 4,
  parameter int unsigned buf_depth               = 4,
  parameter int unsigned credit_width            = 3
) (
  input logic                clk,
  input logic                rst,
  vc_credit_tracker_if.slave vc
);

  localparam logic [credit_width-1:0] BufDepth = credit_width'(buf_depth);
  localparam logic [credit_width-1:0] One      = credit_width'(1);

  logic [credit_width-1:0] r_credit   [no_vc];
  logic [credit_width-1:0] w_credit_d [no_vc];
  logic [no_vc-1:0]        w_grant_hit;
  logic [no_vc-1:0]        w_credit_hit;
  logic [no_vc-1:0]        w_allows;

  // Decode valid indices to one-hot VC selects; indices >= no_vc select nothing.
  always_comb begin
    w_grant_hit  = '0;
    w_credit_hit = '0;
    for (int k = 0; k < int'(no_vc); k++) begin
      w_grant_hit[k]  = vc.grant_valid  && (vc.grant_vc  == floorplusone_log2_no_vc'(k));
      w_credit_hit[k] = vc.credit_valid && (vc.credit_vc == floorplusone_log2_no_vc'(k));
    end
  end

  // Next counter values: same-VC grant+credit nets to zero, otherwise saturating +/-1.
  always_comb begin
    for (int k = 0; k < int'(no_vc); k++) begin
      w_credit_d[k] = r_credit[k];
      if (w_grant_hit[k] && !w_credit_hit[k]) begin
        if (r_credit[k] != '0) w_credit_d[k] = r_credit[k] - One;
      end else if (w_credit_hit[k] && !w_grant_hit[k]) begin
        if (r_credit[k] != BufDepth) w_credit_d[k] = r_credit[k] + One;
      end
    end
  end

  // Counter registers; async reset refills every VC to full depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(no_vc); k++) r_credit[k] <= BufDepth;
    end else begin
      for (int k = 0; k < int'(no_vc); k++) r_credit[k] <= w_credit_d[k];
    end
  end

  // allows comes straight from registered state so reset shows through without a clock.
  always_comb begin
    w_allows = '0;
    for (int k = 0; k < int'(no_vc); k++) w_allows[k] = (r_credit[k] != '0);
  end

  assign vc.allows = w_allows;

`ifdef VC_CREDIT_ERR_EN
  logic w_viol;
  logic r_credit_err;

  // Flag any grant on an empty VC, credit on a full VC, or index outside the VC range.
  always_comb begin
    w_viol = (vc.grant_valid  && (int'(vc.grant_vc)  >= int'(no_vc))) ||
             (vc.credit_valid && (int'(vc.credit_vc) >= int'(no_vc)));
    for (int k = 0; k < int'(no_vc); k++) begin
      if (w_grant_hit[k] && !w_credit_hit[k] && (r_credit[k] == '0))      w_viol = 1'b1;
      if (w_credit_hit[k] && !w_grant_hit[k] && (r_credit[k] == BufDepth)) w_viol = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_credit_err <= 1'b0;
    else if (w_viol) r_credit_err <= 1'b1;
  end

  assign vc.credit_err = r_credit_err;
`endif

endmodule

// File: tb/tb_vc_credit_tracker.sv
// Self-checking bench for vc_credit_tracker: directed scenarios plus randomized traffic,
// compared every cycle against a per-VC credit-count model.
module tb_vc_credit_tracker;
  localparam int NV = 15;
  localparam int W  = 4;
  localparam int BD = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vc_credit_tracker_if #(.no_vc(NV), .floorplusone_log2_no_vc(W)) vc_if ();

  vc_credit_tracker #(
    .no_vc                  (NV),
    .floorplusone_log2_no_vc(W),
    .buf_depth              (BD),
    .credit_width           (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vc (vc_if)
  );

  int model [NV];
  bit m_err;
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_allows();
    logic [31:0] a;
    a = '0;
    for (int k = 0; k < NV; k++) a[k] = (model[k] > 0);
    return a;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NV; k++) model[k] = BD;
    m_err = 1'b0;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ".allows"}, {17'b0, vc_if.allows}, exp_allows());
`ifdef VC_CREDIT_ERR_EN
    check_eq({tag, ".err"}, {31'b0, vc_if.credit_err}, {31'b0, m_err});
`endif
  endtask

  // One clock of traffic; the model applies the counting rules to the pre-edge counts.
  task automatic step(input bit gv, input int gvc, input bit cv, input int cvc,
                      input string tag);
    logic [31:0] gi, ci;
    gi = gvc;
    ci = cvc;
    vc_if.grant_valid  = gv;
    vc_if.grant_vc     = gi[W-1:0];
    vc_if.credit_valid = cv;
    vc_if.credit_vc    = ci[W-1:0];
    @(posedge clk);
    if (gv && gvc >= NV) m_err = 1'b1;
    if (cv && cvc >= NV) m_err = 1'b1;
    for (int k = 0; k < NV; k++) begin
      int net;
      net = ((cv && cvc == k) ? 1 : 0) - ((gv && gvc == k) ? 1 : 0);
      if (net < 0 && model[k] == 0)  m_err = 1'b1;
      else if (net > 0 && model[k] == BD) m_err = 1'b1;
      else model[k] = model[k] + net;
    end
    #1;
    check_state(tag);
    vc_if.grant_valid  = 1'b0;
    vc_if.credit_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    vc_if.grant_valid  = 1'b0;
    vc_if.grant_vc     = '0;
    vc_if.credit_valid = 1'b0;
    vc_if.credit_vc    = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("reset.allows", {17'b0, vc_if.allows}, 32'h7FFF);
`ifdef VC_CREDIT_ERR_EN
    check_eq("reset.err", {31'b0, vc_if.credit_err}, 32'd0);
`endif

    // Drain VC 3, then one grant too many
    for (int i = 0; i < 4; i++) step(1, 3, 0, 0, "drain");
    check_eq("drain.empty", {17'b0, vc_if.allows}, 32'h7FF7);
    step(1, 3, 0, 0, "drain.under");
    check_eq("drain.under.allows", {17'b0, vc_if.allows}, 32'h7FF7);

    // Refill VC 3, then one credit too many
    step(0, 0, 1, 3, "refill1");
    check_eq("refill.first", {17'b0, vc_if.allows}, 32'h7FFF);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 3, "refill");
    step(0, 0, 1, 3, "refill.over");
    // Count must be exactly 4: four grants empty it again
    for (int i = 0; i < 3; i++) step(1, 3, 0, 0, "recount");
    check_eq("recount.3", {17'b0, vc_if.allows}, 32'h7FFF);
    step(1, 3, 0, 0, "recount.4");
    check_eq("recount.4b", {17'b0, vc_if.allows}, 32'h7FF7);

    // Same-cycle grant and credit
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 5, 0, 0, "same.drain");
    step(1, 5, 1, 5, "same.zero");
    check_eq("same.zero.a5", {31'b0, vc_if.allows[5]}, 32'd0);
    step(1, 6, 0, 0, "same.v6a");
    step(1, 6, 0, 0, "same.v6b");
    step(1, 6, 1, 7, "diff.vc");
    step(1, 6, 0, 0, "diff.v6last");
    check_eq("diff.v6empty", {31'b0, vc_if.allows[6]}, 32'd0);

    // Out-of-range index
    do_reset();
    step(1, 15, 0, 0, "oor.grant");
    check_eq("oor.allows", {17'b0, vc_if.allows}, 32'h7FFF);
    do_reset();
    step(0, 0, 1, 15, "oor.credit");

    // Async reset mid-drain: VC 0 left at 1
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "async.drain");
    #2;
    rst = 1'b1;
    #1;
    check_eq("async.allows", {17'b0, vc_if.allows}, 32'h7FFF);
`ifdef VC_CREDIT_ERR_EN
    check_eq("async.err", {31'b0, vc_if.credit_err}, 32'd0);
`endif
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 0, 0, 0, "async.after");

    // Randomized traffic, biased toward a few VCs to hit both saturation limits
    for (int i = 0; i < 3000; i++) begin
      int gvc, cvc;
      gvc = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      cvc = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      if ($urandom_range(0, 249) == 0) do_reset();
      step(1'($urandom_range(0, 1)), gvc, 1'($urandom_range(0, 1)), cvc, "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Guard against any unexpected stall of the run.
  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
